// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus layout, exception codes and CP0 addresses.
package wb_stage_pkg;

    localparam int unsigned MS_TO_WS_BUS_WD = 110;
    localparam int unsigned WS_TO_RF_BUS_WD = 38;

    localparam logic [31:0] EX_ENTRY = 32'hbfc0_0380;

    localparam logic [4:0] NO_EX    = 5'h1f;
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // CP0 register addresses as {rd, sel}
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    typedef struct packed {
        logic        pc_error;
        logic [31:0] badvaddr;
        logic [4:0]  ex_code;
        logic        eret;
        logic        slot;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, Count, Compare and the
// timer/interrupt-pending logic.
module cp0_regs
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  hw_int,
    input  logic        ex_commit,
    input  logic [4:0]  ex_code,
    input  logic        ex_slot,
    input  logic [31:0] ex_pc,
    input  logic        ex_pc_error,
    input  logic [31:0] ex_badvaddr,
    input  logic        eret_commit,
    input  logic        mtc0_we,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] mtc0_wdata,
    output logic [31:0] cp0_rdata_c,
    output logic [31:0] epc,
    output logic        int_pending_c
);

    logic [7:0]  status_im_q, status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic        cause_ti_q, cause_ti_d;
    logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;

    always_comb begin
        status_im_d   = status_im_q;
        status_exl_d  = status_exl_q;
        status_ie_d   = status_ie_q;
        cause_bd_d    = cause_bd_q;
        cause_ip_sw_d = cause_ip_sw_q;
        cause_exc_d   = cause_exc_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        compare_d     = compare_q;
        tick_d        = ~tick_q;
        count_d       = count_q + 32'(tick_q);
        cause_ti_d    = cause_ti_q | (count_q == compare_q);
        cause_ip_hw_d = {hw_int[5] | cause_ti_q, hw_int[4:0]};

        if (mtc0_we) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    status_im_d  = mtc0_wdata[15:8];
                    status_exl_d = mtc0_wdata[1];
                    status_ie_d  = mtc0_wdata[0];
                end
                CP0_CAUSE:   cause_ip_sw_d = mtc0_wdata[9:8];
                CP0_EPC:     epc_d         = mtc0_wdata;
                CP0_COUNT:   count_d       = mtc0_wdata;
                // a Compare write acknowledges the timer and masks a same-cycle match
                CP0_COMPARE: begin
                    compare_d  = mtc0_wdata;
                    cause_ti_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (ex_commit) begin
            status_exl_d = 1'b1;
            cause_exc_d  = ex_code;
            cause_bd_d   = ex_slot;
            if (!status_exl_q) begin
                epc_d = ex_slot ? (ex_pc - 32'd4) : ex_pc;
            end
            if (is_addr_err(ex_code)) begin
                badvaddr_d = ex_pc_error ? ex_pc : ex_badvaddr;
            end
        end

        if (eret_commit) begin
            status_exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im_q   <= '0;
            status_exl_q  <= 1'b0;
            status_ie_q   <= 1'b0;
            cause_bd_q    <= 1'b0;
            cause_ti_q    <= 1'b0;
            cause_ip_hw_q <= '0;
            cause_ip_sw_q <= '0;
            cause_exc_q   <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            tick_q        <= 1'b0;
        end else begin
            status_im_q   <= status_im_d;
            status_exl_q  <= status_exl_d;
            status_ie_q   <= status_ie_d;
            cause_bd_q    <= cause_bd_d;
            cause_ti_q    <= cause_ti_d;
            cause_ip_hw_q <= cause_ip_hw_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            cause_exc_q   <= cause_exc_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            tick_q        <= tick_d;
        end
    end

    always_comb begin
        case (cp0_addr)
            CP0_STATUS:   cp0_rdata_c = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
            CP0_CAUSE:    cp0_rdata_c = {cause_bd_q, cause_ti_q, 14'b0, cause_ip_hw_q, cause_ip_sw_q,
                                         1'b0, cause_exc_q, 2'b0};
            CP0_EPC:      cp0_rdata_c = epc_q;
            CP0_BADVADDR: cp0_rdata_c = badvaddr_q;
            CP0_COUNT:    cp0_rdata_c = count_q;
            CP0_COMPARE:  cp0_rdata_c = compare_q;
            default:      cp0_rdata_c = 32'd0;
        endcase
    end

    assign epc           = epc_q;
    assign int_pending_c = status_ie_q && !status_exl_q &&
                           |({cause_ip_hw_q, cause_ip_sw_q} & status_im_q);

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: commits RF writes, drives the trace, and takes
// exceptions/interrupts/ERET at commit using the CP0 block.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    input  logic                       MFC0,
    input  logic                       MTC0,
    input  logic [7:0]                 cp0_addr,
    input  logic [5:0]                 hw_int,
    output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic [4:0]                 WB_dest,
    output logic [31:0]                WB_dest_data,
    output logic                       WS_EX,
    output logic                       ERET,
    output logic [31:0]                ws_redirect_pc,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic          ws_valid_q, ws_valid_d;
    ms_to_ws_bus_t bus_q, bus_d;
    logic          mfc0_q, mfc0_d;
    logic          mtc0_q, mtc0_d;
    logic [7:0]    cp0_addr_q, cp0_addr_d;

    logic [4:0]    ex_code_c;
    logic          ws_ex_c;
    logic          eret_c;
    logic          rf_we_c;
    logic [31:0]   rf_wdata_c;
    logic [31:0]   cp0_rdata_c;
    logic [31:0]   epc;
    logic          int_pending_c;

    always_comb begin
        ws_valid_d = ms_to_ws_valid;
        bus_d      = bus_q;
        mfc0_d     = mfc0_q;
        mtc0_d     = mtc0_q;
        cp0_addr_d = cp0_addr_q;
        if (ms_to_ws_valid) begin
            bus_d      = ms_to_ws_bus_t'(ms_to_ws_bus);
            mfc0_d     = MFC0;
            mtc0_d     = MTC0;
            cp0_addr_d = cp0_addr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
            mfc0_q     <= 1'b0;
            mtc0_q     <= 1'b0;
            cp0_addr_q <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
            mfc0_q     <= mfc0_d;
            mtc0_q     <= mtc0_d;
            cp0_addr_q <= cp0_addr_d;
        end
    end

    // a pending interrupt outranks whatever the instruction itself raised
    assign ex_code_c  = (ws_valid_q && int_pending_c) ? EXC_INT : bus_q.ex_code;
    assign ws_ex_c    = ws_valid_q && (ex_code_c != NO_EX);
    assign eret_c     = ws_valid_q && bus_q.eret && !ws_ex_c;
    assign rf_we_c    = ws_valid_q && bus_q.gr_we && !ws_ex_c;
    assign rf_wdata_c = mfc0_q ? cp0_rdata_c : bus_q.result;

    cp0_regs u_cp0_regs (
        .clk           (clk),
        .resetn        (resetn),
        .hw_int        (hw_int),
        .ex_commit     (ws_ex_c),
        .ex_code       (ex_code_c),
        .ex_slot       (bus_q.slot),
        .ex_pc         (bus_q.pc),
        .ex_pc_error   (bus_q.pc_error),
        .ex_badvaddr   (bus_q.badvaddr),
        .eret_commit   (eret_c),
        .mtc0_we       (ws_valid_q && mtc0_q && !ws_ex_c),
        .cp0_addr      (cp0_addr_q),
        .mtc0_wdata    (bus_q.result),
        .cp0_rdata_c   (cp0_rdata_c),
        .epc           (epc),
        .int_pending_c (int_pending_c)
    );

    assign ws_allowin        = 1'b1;
    assign ws_to_rf_bus      = {rf_we_c, bus_q.dest, rf_wdata_c};
    assign WB_dest           = ws_valid_q ? bus_q.dest : 5'd0;
    assign WB_dest_data      = rf_wdata_c;
    assign WS_EX             = ws_ex_c;
    assign ERET              = eret_c;
    assign ws_redirect_pc    = ws_ex_c ? EX_ENTRY : (eret_c ? epc : 32'd0);
    assign debug_wb_pc       = bus_q.pc;
    assign debug_wb_rf_wen   = {4{rf_we_c}};
    assign debug_wb_rf_wnum  = bus_q.dest;
    assign debug_wb_rf_wdata = rf_wdata_c;

endmodule
